// File: rtl/huffman_packer_if.sv
// Handshake bundle for huffman_packer: code-table load, symbol stream in, packed byte stream out.
interface huffman_packer_if;
    logic        code_valid;
    logic [47:0] hc_bus;
    logic [47:0] m_bus;
    logic        sym_valid;
    logic [7:0]  sym_data;
    logic        sym_last;
    logic        sym_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_last;
    logic        out_ready;
    logic        frame_done;
    logic        sym_err;

    modport slave (
        input  code_valid, hc_bus, m_bus, sym_valid, sym_data, sym_last, out_ready,
        output sym_ready, out_valid, out_data, out_last, frame_done, sym_err
    );

    modport master (
        output code_valid, hc_bus, m_bus, sym_valid, sym_data, sym_last, out_ready,
        input  sym_ready, out_valid, out_data, out_last, frame_done, sym_err
    );
endinterface

// File: rtl/huffman_packer.sv
// Packs variable-length Huffman codes MSB-first into bytes; a symbol is appended the cycle it is accepted.
// Bytes appear combinationally from the buffer; sym_ready drops above 11 buffered bits, outputs hold while out_ready is low.
module huffman_packer (
    input  logic             clk,
    input  logic             reset,
    huffman_packer_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_READY, S_STREAM, S_FLUSH} state_t;

    state_t      state, state_nx;
    logic [7:0]  code_tab [6];
    logic [3:0]  len_tab  [6];
    logic [15:0] bit_buf, buf_nx;
    logic [4:0]  cnt, cnt_nx;
    logic        sym_err_q, frame_done_q;
    logic        frame_done_nx;

    logic [7:0]  sel_code;
    logic [3:0]  sel_len;
    logic        sym_legal;
    logic        accept, xfer, load;
    logic        out_valid_c, out_last_c;
    logic [7:0]  tail_mask;
    logic [15:0] base_buf;
    logic [4:0]  base_cnt;
    logic [5:0]  shamt;
    logic [23:0] placed;

    // Out-of-range symbols select nothing, so their length reads as zero.
    always_comb begin
        sel_code = 8'd0;
        sel_len  = 4'd0;
        for (int k = 0; k < 6; k++) begin
            if (bus.sym_data == 8'(k + 1)) begin
                sel_code = code_tab[k];
                sel_len  = len_tab[k];
            end
        end
    end

    assign sym_legal     = (sel_len != 4'd0);
    assign bus.sym_ready = ((state == S_READY) || (state == S_STREAM)) && (cnt <= 5'd11);
    assign accept        = bus.sym_valid && bus.sym_ready;
    assign load          = bus.code_valid && ((state == S_IDLE) || (state == S_READY));

    assign out_valid_c = ((state == S_STREAM) && (cnt >= 5'd9)) ||
                         ((state == S_FLUSH)  && (cnt != 5'd0));
    assign out_last_c  = (state == S_FLUSH) && (cnt != 5'd0) && (cnt <= 5'd8);
    assign tail_mask   = (cnt >= 5'd8) ? 8'hFF : ~(8'hFF >> cnt[2:0]);
    assign xfer        = out_valid_c && bus.out_ready;

    assign bus.out_valid  = out_valid_c;
    assign bus.out_last   = out_last_c;
    assign bus.out_data   = bit_buf[15:8] & tail_mask;
    assign bus.frame_done = frame_done_q;
    assign bus.sym_err    = sym_err_q;

    // Shift-out is applied first so a same-cycle append lands after the surviving bits.
    assign base_buf = xfer ? {bit_buf[7:0], 8'd0} : bit_buf;
    assign base_cnt = xfer ? (cnt - 5'd8) : cnt;
    assign shamt    = 6'd24 - {1'b0, base_cnt} - {2'b00, sel_len};
    assign placed   = {16'd0, sel_code} << shamt;

    always_comb begin
        state_nx      = state;
        buf_nx        = bit_buf;
        cnt_nx        = cnt;
        frame_done_nx = 1'b0;

        if (xfer) begin
            buf_nx = base_buf;
            cnt_nx = base_cnt;
        end
        if (accept && sym_legal) begin
            buf_nx = base_buf | placed[23:8];
            cnt_nx = base_cnt + {1'b0, sel_len};
        end

        case (state)
            S_IDLE: begin
                if (bus.code_valid) state_nx = S_READY;
            end
            S_READY: begin
                if (accept) state_nx = bus.sym_last ? S_FLUSH : S_STREAM;
            end
            S_STREAM: begin
                if (accept && bus.sym_last) state_nx = S_FLUSH;
            end
            S_FLUSH: begin
                if ((cnt == 5'd0) || (xfer && out_last_c)) begin
                    state_nx      = S_READY;
                    buf_nx        = 16'd0;
                    cnt_nx        = 5'd0;
                    frame_done_nx = 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            bit_buf      <= 16'd0;
            cnt          <= 5'd0;
            sym_err_q    <= 1'b0;
            frame_done_q <= 1'b0;
            for (int k = 0; k < 6; k++) begin
                code_tab[k] <= 8'd0;
                len_tab[k]  <= 4'd0;
            end
        end else begin
            state        <= state_nx;
            bit_buf      <= buf_nx;
            cnt          <= cnt_nx;
            sym_err_q    <= accept && !sym_legal;
            frame_done_q <= frame_done_nx;
            if (load) begin
                for (int k = 0; k < 6; k++) begin
                    code_tab[k] <= bus.hc_bus[8*k +: 8] & bus.m_bus[8*k +: 8];
                    len_tab[k]  <= 4'($countones(bus.m_bus[8*k +: 8]));
                end
            end
        end
    end
endmodule

// File: tb/tb_huffman_packer.sv
// Directed bench for huffman_packer: table-driven frames plus stall, table-swap and reset sequences.
module tb_huffman_packer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    huffman_packer_if bus();
    huffman_packer u_dut (.clk(clk), .reset(reset), .bus(bus));

    localparam logic [47:0] T1_HC = {8'h08, 8'h09, 8'h05, 8'h03, 8'h00, 8'h01};
    localparam logic [47:0] T1_M  = {8'h1F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01};
    localparam logic [47:0] T2_HC = 48'h01_01_01_01_01_01;
    localparam logic [47:0] T3_HC = 48'h03_03_03_03_03_03;

    typedef struct packed {
        logic [95:0] syms;
        logic [3:0]  nsym;
        logic [31:0] bytes;
        logic [2:0]  nbytes;
        logic [1:0]  nerr;
    } vec_t;

    vec_t       vecs [8];
    logic [7:0] out_q  [$];
    logic       last_q [$];
    int         fd_cnt, err_cnt;
    int         n_cmp = 0;
    int         n_bad = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.out_valid && bus.out_ready) begin
                out_q.push_back(bus.out_data);
                last_q.push_back(bus.out_last);
            end
            if (bus.frame_done) fd_cnt++;
            if (bus.sym_err)    err_cnt++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        out_q.delete();
        last_q.delete();
        fd_cnt  = 0;
        err_cnt = 0;
    endtask

    task automatic load_table(input logic [47:0] hc, input logic [47:0] m);
        bus.code_valid = 1'b1;
        bus.hc_bus     = hc;
        bus.m_bus      = m;
        @(posedge clk); #1;
        bus.code_valid = 1'b0;
    endtask

    task automatic send_sym(input logic [7:0] s, input logic last);
        bit ok = 1'b0;
        bus.sym_valid = 1'b1;
        bus.sym_data  = s;
        bus.sym_last  = last;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk);
            if (bus.sym_ready) ok = 1'b1;
        end
        @(posedge clk); #1;
        bus.sym_valid = 1'b0;
        bus.sym_last  = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sym_accept timeout: got no sym_ready, want sym_ready within 100 cycles");
        end
    endtask

    task automatic wait_done(input string tag);
        bit done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(posedge clk);
            if (fd_cnt > 0) done = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s frame_done timeout: got none, want a pulse within 200 cycles", tag);
        end
    endtask

    task automatic check_frame(input string tag, input logic [31:0] bytes, input int nbytes, input int nerr);
        check({tag, " nbytes"}, 32'(out_q.size()), 32'(nbytes));
        for (int j = 0; j < nbytes && j < out_q.size(); j++) begin
            check($sformatf("%s byte%0d", tag, j), 32'(out_q[j]), 32'(bytes[31-8*j -: 8]));
            check($sformatf("%s last%0d", tag, j), 32'(last_q[j]), 32'(j == nbytes - 1));
        end
        check({tag, " sym_err"}, 32'(err_cnt), 32'(nerr));
        check({tag, " frame_done"}, 32'(fd_cnt), 32'd1);
    endtask

    initial begin
        int acc;
        int unstable;

        vecs[0] = '{syms: {8'd2, 8'd3, 8'd4, 72'd0},         nsym: 4'd3, bytes: 32'h1A80_0000, nbytes: 3'd2, nerr: 2'd0};
        vecs[1] = '{syms: {{9{8'd1}}, 24'd0},                nsym: 4'd9, bytes: 32'hFF80_0000, nbytes: 3'd2, nerr: 2'd0};
        vecs[2] = '{syms: {8'd2, 8'd3, 8'd7, 8'd4, 64'd0},   nsym: 4'd4, bytes: 32'h1A80_0000, nbytes: 3'd2, nerr: 2'd1};
        vecs[3] = '{syms: {8'd5, 8'd6, 80'd0},               nsym: 4'd2, bytes: 32'h4A00_0000, nbytes: 3'd2, nerr: 2'd0};
        vecs[4] = '{syms: {{4{8'd4}}, 64'd0},                nsym: 4'd4, bytes: 32'h5555_0000, nbytes: 3'd2, nerr: 2'd0};
        vecs[5] = '{syms: {8'd0, 88'd0},                     nsym: 4'd1, bytes: 32'h0000_0000, nbytes: 3'd0, nerr: 2'd1};
        vecs[6] = '{syms: {8'd1, 88'd0},                     nsym: 4'd1, bytes: 32'h8000_0000, nbytes: 3'd1, nerr: 2'd0};
        vecs[7] = '{syms: {{3{8'd6}}, 72'd0},                nsym: 4'd3, bytes: 32'h4210_0000, nbytes: 3'd2, nerr: 2'd0};

        bus.code_valid = 1'b0;
        bus.hc_bus     = '0;
        bus.m_bus      = '0;
        bus.sym_valid  = 1'b0;
        bus.sym_data   = '0;
        bus.sym_last   = 1'b0;
        bus.out_ready  = 1'b1;
        clear_mon();

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst sym_ready",  32'(bus.sym_ready),  32'd0);
        check("rst out_valid",  32'(bus.out_valid),  32'd0);
        check("rst out_data",   32'(bus.out_data),   32'd0);
        check("rst out_last",   32'(bus.out_last),   32'd0);
        check("rst frame_done", 32'(bus.frame_done), 32'd0);
        check("rst sym_err",    32'(bus.sym_err),    32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        bus.sym_valid = 1'b1;
        bus.sym_data  = 8'd1;
        repeat (2) @(negedge clk);
        check("idle sym_ready", 32'(bus.sym_ready), 32'd0);
        @(posedge clk); #1;
        bus.sym_valid = 1'b0;

        load_table(T1_HC, T1_M);
        for (int i = 0; i < 8; i++) begin
            clear_mon();
            for (int s = 0; s < int'(vecs[i].nsym); s++)
                send_sym(vecs[i].syms[95-8*s -: 8], s == int'(vecs[i].nsym) - 1);
            wait_done($sformatf("v%0d", i));
            check_frame($sformatf("v%0d", i), vecs[i].bytes, int'(vecs[i].nbytes), int'(vecs[i].nerr));
        end

        // Backpressure: twelve 1-bit symbols fill the buffer, then the sink releases.
        clear_mon();
        acc = 0;
        unstable = 0;
        bus.out_ready = 1'b0;
        bus.sym_valid = 1'b1;
        bus.sym_data  = 8'd1;
        bus.sym_last  = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.sym_ready) acc++;
            if (bus.out_valid && bus.out_data != 8'hFF) unstable++;
        end
        check("stall accepts",   32'(acc),            32'd12);
        check("stall sym_ready", 32'(bus.sym_ready),  32'd0);
        check("stall out_valid", 32'(bus.out_valid),  32'd1);
        check("stall out_data",  32'(bus.out_data),   32'hFF);
        check("stall unstable",  32'(unstable),       32'd0);
        @(posedge clk); #1;
        bus.sym_valid = 1'b0;
        bus.out_ready = 1'b1;
        send_sym(8'd1, 1'b1);
        wait_done("stall");
        check_frame("stall", 32'hFFF8_0000, 2, 0);

        // Table swap attempted mid-stream is ignored; a load in READY takes effect.
        clear_mon();
        send_sym(8'd2, 1'b0);
        load_table(T2_HC, T2_HC);
        send_sym(8'd3, 1'b0);
        send_sym(8'd4, 1'b1);
        wait_done("swap_ign");
        check_frame("swap_ign", 32'h1A80_0000, 2, 0);
        load_table(T3_HC, T3_HC);
        clear_mon();
        for (int s = 1; s <= 4; s++) send_sym(8'(s), s == 4);
        wait_done("swap_new");
        check_frame("swap_new", 32'hFF00_0000, 1, 0);

        // Reset with five bits buffered.
        load_table(T1_HC, T1_M);
        clear_mon();
        send_sym(8'd5, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        bus.sym_valid = 1'b1;
        bus.sym_data  = 8'd1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("postrst sym_ready c%0d", c), 32'(bus.sym_ready), 32'd0);
            check($sformatf("postrst out_valid c%0d", c), 32'(bus.out_valid), 32'd0);
        end
        @(posedge clk); #1;
        bus.sym_valid = 1'b0;
        load_table(T1_HC, T1_M);
        clear_mon();
        send_sym(8'd1, 1'b1);
        wait_done("postrst");
        check_frame("postrst", 32'h8000_0000, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/huffman_packer.md
HUFFMAN_PACKER -- requirements
Module: huffman_packer

Interface
REQ-001 clk  input  1  single clock; all state updates on the rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 code_valid  input  1  one-cycle strobe from the code generator; the code table is valid this cycle.
REQ-004 hc_bus  input  48  codes; symbol k (1..6) at bits [8k-1:8k-8]; code is LSB-aligned.
REQ-005 m_bus  input  48  masks, same packing as hc_bus; contiguous ones from bit 0; length = number of ones (0..8).
REQ-006 sym_valid  input  1  symbol-stream valid.
REQ-007 sym_data  input  8  gray value; legal values 1..6.
REQ-008 sym_last  input  1  qualifies the final symbol of a frame.
REQ-009 sym_ready  output  1  the packer accepts a symbol when sym_valid && sym_ready.
REQ-010 out_valid  output  1  out_data holds a packed byte.
REQ-011 out_data  output  8  packed bits; the first-encoded bit is at bit 7.
REQ-012 out_last  output  1  marks the final byte of a frame; qualified by out_valid.
REQ-013 out_ready  input  1  a byte transfers when out_valid && out_ready.
REQ-014 frame_done  output  1  one-cycle pulse when a frame completes.
REQ-015 sym_err  output  1  one-cycle pulse when an accepted symbol is illegal.

Function
REQ-016 States: IDLE (no table), READY (table held, no frame), STREAM, FLUSH.
REQ-017 Table load: code_valid in IDLE or READY latches hc_bus/m_bus into six code/length entries and enters READY; code_valid is ignored in STREAM and FLUSH.
REQ-018 Length is computed at load as popcount(mask), 4-bit.
REQ-019 Bit buffer is 16 bits, left-aligned, with a 5-bit count (0..16).
REQ-020 sym_ready = (state is READY or STREAM) && count <= 11.
REQ-021 Accepted legal symbol: its len code bits are appended code[len-1] first, directly after the existing valid bits; count += len.
REQ-022 Illegal symbol (sym_data 0 or >6, or entry len 0): consumed, buffer unchanged, sym_err pulses the next cycle; sym_last is still honoured.
REQ-023 READY -> STREAM on the first accepted symbol without sym_last; READY or STREAM -> FLUSH on any accepted symbol with sym_last.
REQ-024 STREAM emission: out_valid = count >= 9; out_data = buf[15:8]; out_last = 0; on transfer buf <<= 8, count -= 8.
REQ-025 Simultaneous accept and transfer in one cycle: buffer shift and append combine; count_next = count + len - 8.
REQ-026 FLUSH, count >= 8: emit buf[15:8]; out_last = (count == 8).
REQ-027 FLUSH, 1 <= count <= 7: emit buf[15:8] with unused low bits forced to 0; out_last = 1.
REQ-028 The out_last transfer clears count to 0, pulses frame_done and returns to READY.
REQ-029 FLUSH with count == 0 (all symbols illegal): no byte is emitted; pulse frame_done and return to READY the next cycle.
REQ-030 out_valid, out_data and out_last stay stable while out_valid && !out_ready.
REQ-031 The table persists across frames; a frame length of zero bits is legal (REQ-029).

Reset
REQ-032 Reset sets state to IDLE and clears table, buffer and count; sym_ready, out_valid, out_last, frame_done and sym_err = 0; out_data = 0.
REQ-033 Reset mid-frame discards all buffered bits; the table must be reloaded before sym_ready rises.

Verification
REQ-034 Load table 1:"1"(HC 01/M 01), 2:"00"(00/03), 3:"011"(03/07), 4:"0101"(05/0F), 5:"01001"(09/1F), 6:"01000"(08/1F); send 2,3,4 (last on 4) with out_ready = 1 -> bytes 0x1A, then 0x80 with out_last; frame_done pulses once.
REQ-035 Same table; nine symbol-1 with last on the ninth -> 0xFF, then 0x80 with out_last.
REQ-036 out_ready = 0 while streaming symbol-1 -> sym_ready drops once count = 12; out_data = 0xFF held stable; resumes when out_ready = 1.
REQ-037 Symbol 7 mid-frame -> sym_err pulses; the output bitstream is identical to the frame without it.
REQ-038 code_valid with a different table during STREAM -> ignored; a new frame after frame_done with code_valid in READY uses the new codes.
REQ-039 Reset asserted with 5 bits buffered -> out_valid = 0 and sym_ready = 0 until code_valid; the next frame output contains no stale bits.
